mem_arbiter: RTL

Single-port memory arbiter that shares one unified instruction/data memory between the pipeline's IF-stage fetch port and MEM-stage data port. It serialises requests, holds one transaction in flight, and returns a one-cycle ready pulse to the winning requester. It drives a stall to each requester until its access completes. Data accesses have priority, with an anti-starvation limit so fetch always makes progress.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// bus command codes, FSM state encoding and transaction owner.
package mem_arb_pkg;

  localparam logic [1:0] BUS_NONE  = 2'b00;
  localparam logic [1:0] BUS_LOAD  = 2'b01;
  localparam logic [1:0] BUS_STORE = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, RESP} arb_state_t;

  typedef enum logic {OWN_IF, OWN_D} owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises IF fetches and MEM data accesses onto one
// memory port, data first, with a streak limit so fetch cannot starve.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  if_cmd,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  input  logic [1:0]  d_cmd,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_stall,
  output logic [1:0]  mem_cmd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic [1:0]  dbg_state,
  output logic [7:0]  dbg_streak
);

  localparam int              SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [7:0]      WAIT_LAST  = 8'(TIMEOUT - 1);

  arb_state_t    state, state_nxt;
  owner_t        owner, grant_own;
  logic [1:0]    cmd_q;
  logic [31:0]   addr_q, wdata_q, if_rdata_q, d_rdata_q;
  logic [SW-1:0] streak_cnt, streak_nxt;
  logic [7:0]    wait_cnt;
  logic          if_req, d_req, grant, rd_done, rd_timeout;

  // Handshake: a requester raises cmd and holds cmd/addr/wdata until its ready
  // pulses for one cycle; memory holds mem_cmd stable until mem_ack, and read
  // data is taken only on mem_rvalid while waiting for it.
  always_comb begin
    if_req     = (if_cmd == BUS_LOAD);
    d_req      = (d_cmd == BUS_LOAD) || (d_cmd == BUS_STORE);
    state_nxt  = state;
    grant      = 1'b0;
    grant_own  = OWN_IF;
    rd_done    = 1'b0;
    rd_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          grant     = 1'b1;
          state_nxt = REQ;
          if (d_req && (!if_req || streak_cnt < STREAK_MAX)) grant_own = OWN_D;
        end
      end
      REQ: begin
        if (mem_ack) state_nxt = (cmd_q == BUS_STORE) ? RESP : WAIT_RD;
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          rd_done   = 1'b1;
          state_nxt = RESP;
        end else if (wait_cnt == WAIT_LAST) begin
          rd_done    = 1'b1;
          rd_timeout = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // The streak only counts data wins that actually made fetch wait.
    streak_nxt = streak_cnt;
    if (!if_req || (grant && grant_own == OWN_IF)) streak_nxt = '0;
    else if (grant && streak_cnt != STREAK_MAX)    streak_nxt = streak_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      cmd_q      <= BUS_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      streak_cnt <= '0;
      wait_cnt   <= '0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      streak_cnt <= streak_nxt;
      if (grant) begin
        owner <= grant_own;
        if (grant_own == OWN_D) begin
          cmd_q   <= d_cmd;
          addr_q  <= d_addr;
          wdata_q <= d_wdata;
        end else begin
          cmd_q   <= BUS_LOAD;
          addr_q  <= if_addr;
          wdata_q <= '0;
        end
      end
      if (state == REQ && state_nxt == WAIT_RD)  wait_cnt <= '0;
      else if (state == WAIT_RD && !rd_done)     wait_cnt <= wait_cnt + 8'd1;
      // A timed-out read hands back zeros rather than whatever is on the bus.
      if (rd_done) begin
        if (owner == OWN_D) d_rdata_q  <= rd_timeout ? '0 : mem_rdata;
        else                if_rdata_q <= rd_timeout ? '0 : mem_rdata;
      end
      if (rd_timeout) bus_err <= 1'b1;
    end
  end

  assign mem_cmd    = (state == REQ) ? cmd_q : BUS_NONE;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign if_ready   = (state == RESP) && (owner == OWN_IF);
  assign d_ready    = (state == RESP) && (owner == OWN_D);
  assign if_stall   = if_req & ~if_ready;
  assign d_stall    = d_req & ~d_ready;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign dbg_state  = state;
  assign dbg_streak = 8'(streak_cnt);

endmodule
